busca_menor_distancia: RTL and testbench

BUSCA_MENOR_DISTANCIA -- requirements
Module: busca_menor_distancia

---
 rtl/busca_menor_distancia.sv | 129 ++++++++++++
 tb/tb_busca_menor_distancia.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/busca_menor_distancia.sv
// rtl/busca_menor_distancia.sv - streaming minimum-distance search over N_CANAIS samples per frame
// Optional MENOR_DIST_PRIMEIRO_EN: report the lowest tied index instead of the all-ones sentinel.
module busca_menor_distancia #(
    parameter int N_CANAIS = 10,
    parameter int LARGURA  = 16,
    parameter int IDX_W    = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LARGURA-1:0] in_dado,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_indice,
    output logic [LARGURA-1:0] out_valor,
    output logic               out_empate
);

    typedef enum logic [1:0] {OCIOSO, VARRENDO, PRONTO} estado_t;

    estado_t            estado_q;
    logic [IDX_W-1:0]   cnt_q;
    logic [LARGURA-1:0] min_q, min_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               empate_q, empate_d;
    logic [IDX_W-1:0]   indice_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [IDX_W-1:0]   out_indice_q;
    logic [LARGURA-1:0] out_valor_q;
    logic               out_empate_q;
    logic               aceita;
    logic               ultimo;

    assign aceita = in_valid && in_ready_q;
    assign ultimo = (cnt_q == IDX_W'(N_CANAIS - 1));

    // Running-minimum update for the sample currently on in_dado.
    always_comb begin
        min_d    = min_q;
        idx_d    = idx_q;
        empate_d = empate_q;
        if (estado_q == OCIOSO) begin
            min_d    = in_dado;
            idx_d    = '0;
            empate_d = 1'b0;
        end else if (in_dado < min_q) begin
            min_d    = in_dado;
            idx_d    = cnt_q;
            empate_d = 1'b0;
        end else if (in_dado == min_q) begin
            empate_d = 1'b1;
        end
`ifdef MENOR_DIST_PRIMEIRO_EN
        indice_d = idx_d;
`else
        indice_d = empate_d ? {IDX_W{1'b1}} : idx_d;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_q     <= OCIOSO;
            cnt_q        <= '0;
            min_q        <= '0;
            idx_q        <= '0;
            empate_q     <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_indice_q <= '0;
            out_valor_q  <= '0;
            out_empate_q <= 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (aceita) begin
                        min_q    <= min_d;
                        idx_q    <= idx_d;
                        empate_q <= empate_d;
                        cnt_q    <= IDX_W'(1);
                        estado_q <= VARRENDO;
                    end
                end
                VARRENDO: begin
                    if (aceita) begin
                        min_q    <= min_d;
                        idx_q    <= idx_d;
                        empate_q <= empate_d;
                        if (ultimo) begin
                            cnt_q        <= '0;
                            estado_q     <= PRONTO;
                            in_ready_q   <= 1'b0;
                            out_valid_q  <= 1'b1;
                            out_indice_q <= indice_d;
                            out_valor_q  <= min_d;
                            out_empate_q <= empate_d;
                        end else begin
                            cnt_q <= cnt_q + IDX_W'(1);
                        end
                    end
                end
                PRONTO: begin
                    // in_ready is low here, so the handshake cycle can never take a sample.
                    if (out_ready) begin
                        estado_q     <= OCIOSO;
                        in_ready_q   <= 1'b1;
                        out_valid_q  <= 1'b0;
                        out_indice_q <= '0;
                        out_valor_q  <= '0;
                        out_empate_q <= 1'b0;
                    end
                end
                default: begin
                    estado_q    <= OCIOSO;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_indice = out_indice_q;
    assign out_valor  = out_valor_q;
    assign out_empate = out_empate_q;

endmodule

// File: tb/tb_busca_menor_distancia.sv
// tb/tb_busca_menor_distancia.sv - scoreboard bench for busca_menor_distancia with directed frames
module tb_busca_menor_distancia;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_dado = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_indice;
    logic [15:0] out_valor;
    logic        out_empate;

    typedef struct {
        logic [3:0]  idx;
        logic [15:0] val;
        logic        emp;
    } res_t;

    res_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    busca_menor_distancia #(.N_CANAIS(10), .LARGURA(16), .IDX_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_dado    (in_dado),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_indice (out_indice),
        .out_valor  (out_valor),
        .out_empate (out_empate)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every result handshake; idle outputs must read zero.
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    res_t e;
                    e = sb_q.pop_front();
                    chk("out_indice", 32'(out_indice), 32'(e.idx));
                    chk("out_valor", 32'(out_valor), 32'(e.val));
                    chk("out_empate", 32'(out_empate), 32'(e.emp));
                end
            end else if (!out_valid) begin
                chk("idle_outputs_zero", {11'd0, out_indice, out_valor, out_empate}, 32'd0);
            end
        end
    end

    task automatic send(input logic [15:0] d[10], input int n, input bit toggle, input bit lat_chk);
        for (int i = 0; i < n; i++) begin
            int w;
            @(negedge clk);
            in_valid = 1'b1;
            in_dado  = d[i];
            w = 0;
            while (!in_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (w == 50) chk("in_ready_timeout", 32'd0, 32'd1);
            if (lat_chk && i == n - 1) chk("out_valid_before_last", 32'(out_valid), 32'd0);
            @(posedge clk);
            if (toggle && i < n - 1) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (lat_chk) chk("out_valid_latency", 32'(out_valid), 32'd1);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 40) begin
            @(posedge clk);
            #2;
            w++;
        end
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    endtask

    function automatic res_t mk(input logic [3:0] i, input logic [15:0] v, input logic e);
        res_t r;
        r.idx = i;
        r.val = v;
        r.emp = e;
        return r;
    endfunction

    logic [15:0] fa[10] = '{16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
    logic [15:0] fb[10] = '{16'd5, 16'd3, 16'd9, 16'd3, 16'd7, 16'd8, 16'd6, 16'd4, 16'd10, 16'd11};
    logic [15:0] fc[10] = '{16'd4, 16'd4, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd2};
    logic [15:0] fd[10] = '{16'd1, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5};
    logic [15:0] fe[10] = '{16'd7, 16'd7, 16'd7, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    logic [15:0] ff[10] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                            16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0001};

`ifdef MENOR_DIST_PRIMEIRO_EN
    localparam logic [3:0] IDX_EMPATE = 4'd1;
`else
    localparam logic [3:0] IDX_EMPATE = 4'd15;
`endif

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs", {11'd0, out_indice, out_valor, out_empate}, 32'd0);
        reset_n = 1'b1;

        // Descending, tie, early tie cleared.
        sb_q.push_back(mk(4'd9, 16'd0, 1'b0));
        send(fa, 10, 1'b0, 1'b1);
        drain();
        sb_q.push_back(mk(IDX_EMPATE, 16'd3, 1'b1));
        send(fb, 10, 1'b0, 1'b1);
        drain();
        sb_q.push_back(mk(4'd9, 16'd2, 1'b0));
        send(fc, 10, 1'b0, 1'b1);
        drain();

        // Back-pressure: result held for 5 cycles while in_valid offers a zero.
        out_ready = 1'b0;
        sb_q.push_back(mk(4'd9, 16'd0, 1'b0));
        send(fa, 10, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_dado  = 16'd0;
        for (int k = 0; k < 5; k++) begin
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_outputs", {11'd0, out_indice, out_valor, out_empate}, {11'd0, 4'd9, 16'd0, 1'b0});
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_handshake_out_valid", 32'(out_valid), 32'd0);
        chk("post_handshake_in_ready", 32'(in_ready), 32'd1);
        chk("scoreboard_after_stall", 32'(sb_q.size()), 32'd0);
        sb_q.push_back(mk(4'd0, 16'd1, 1'b0));
        send(fd, 10, 1'b0, 1'b1);
        drain();

        // Reset mid-frame discards the partial scan.
        send(fe, 4, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_outputs", {11'd0, out_indice, out_valor, out_empate}, 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        sb_q.push_back(mk(4'd9, 16'd1, 1'b0));
        send(ff, 10, 1'b0, 1'b1);
        drain();

        // Gapped input gives the same result as back-to-back.
        sb_q.push_back(mk(IDX_EMPATE, 16'd3, 1'b1));
        send(fb, 10, 1'b1, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
